// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG initiator for user-chain IR/DR scans.
// Walks the TAP from Run-Test/Idle through Shift and back; drives TCK/TMS/TDI.
// Ports: CLK, RST (async, active-high)
//        cmd_valid/cmd_ready, cmd_is_ir, cmd_len, cmd_data (LSB first)
//        rsp_valid (1-cycle pulse), rsp_data (captured TDO, LSB first)
//        TCK, TMS, TDI (to target), TDO (from target)
module jtag_scan_master #(
    parameter int DIV      = 4,
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                TCK,
    output logic                TMS,
    output logic                TDI,
    input  logic                TDO
);

    localparam int CNT_W = (DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam int IDX_W = LEN_W + 2;
    localparam int K_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(DIV - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BITS);

    typedef enum logic [1:0] {INIT, IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    len;
    logic                is_ir;
    logic [MAX_BITS-1:0] dreg;
    logic [MAX_BITS-1:0] cap;

    logic                accept;
    logic [IDX_W-1:0]    off;
    logic [IDX_W-1:0]    n_pulses;
    logic [K_W-1:0]      k_nxt;
    logic [K_W-1:0]      k_cur;
    logic                sh_nxt;
    logic                sh_cur;
    logic                tms_nxt;
    logic                seq_end;

    assign accept = cmd_valid && cmd_ready;

    // idx counts pulses already issued: idx is the next pulse to
    // launch, idx-1 the pulse currently on the wire.
    always_comb begin
        off      = is_ir ? IDX_W'(4) : IDX_W'(3);
        n_pulses = (state == INIT) ? IDX_W'(6) : off + len + IDX_W'(2);
        k_nxt    = K_W'(idx - off);
        k_cur    = K_W'(idx - off - IDX_W'(1));
        sh_nxt   = (state == RUN) && (idx >= off) && (idx < off + len);
        sh_cur   = (state == RUN) && (idx > off) && (idx <= off + len);
        seq_end  = (idx == n_pulses) || ((state == RUN) && (len == '0));
        if (state == INIT) begin
            tms_nxt = (idx < IDX_W'(5));
        end else if (idx < off) begin
            tms_nxt = (idx == '0) || (is_ir && (idx == IDX_W'(1)));
        end else if (idx + IDX_W'(1) < off + len) begin
            tms_nxt = 1'b0;
        end else begin
            tms_nxt = (idx <= off + len);
        end
    end

    // A sequence starts with cnt parked at the fall point, so its first
    // cycle behaves like a TCK fall and launches pulse 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= INIT;
            cnt       <= CNT_TOP;
            idx       <= '0;
            len       <= '0;
            is_ir     <= 1'b0;
            dreg      <= '0;
            cap       <= '0;
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    TCK       <= 1'b0;
                    TMS       <= 1'b0;
                    TDI       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                    if (accept) begin
                        state     <= RUN;
                        cmd_ready <= 1'b0;
                        is_ir     <= cmd_is_ir;
                        len       <= (cmd_len > MAX_LEN) ? IDX_W'(MAX_LEN)
                                                         : IDX_W'(cmd_len);
                        dreg      <= cmd_data;
                        cap       <= '0;
                        idx       <= '0;
                        cnt       <= CNT_TOP;
                    end
                end
                INIT, RUN: begin
                    if (cnt == CNT_TOP) begin
                        TCK <= 1'b0;
                        cnt <= '0;
                        if (seq_end) begin
                            TMS       <= 1'b0;
                            TDI       <= 1'b0;
                            cmd_ready <= 1'b1;
                            if (state == INIT) begin
                                state <= IDLE;
                            end else begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= cap;
                            end
                        end else begin
                            TMS <= tms_nxt;
                            TDI <= sh_nxt & dreg[k_nxt];
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_RISE) begin
                            TCK <= 1'b1;
                            if (sh_cur) begin
                                cap[k_cur] <= TDO;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed + random scans against a TAP/chain model.
// Checks TMS/TDI pulse trains, captured data, latency, init and reset.
module tb_jtag_scan_master;

    localparam int DIV = 2;
    localparam int MB  = 32;
    localparam int LW  = $clog2(MB + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_is_ir = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic [MB-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [MB-1:0] rsp_data;
    logic          TCK;
    logic          TMS;
    logic          TDI;
    logic          TDO = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    jtag_scan_master #(.DIV(DIV), .MAX_BITS(MB), .LEN_W(LW)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    // target TAP: 4-bit DR (capture 4'hA), 8-bit IR (capture 8'h01)
    typedef enum logic [3:0] {
        TLR, RTI, SDS, CDR, SHD, E1D, PDR, E2D, UDR,
        SIS, CIR, SHI, E1I, PIR, E2I, UIR
    } tap_t;

    tap_t       tap = TLR;
    logic [3:0] sr_dr = '0;
    logic [3:0] upd_dr = '0;
    logic [7:0] sr_ir = '0;
    logic [7:0] upd_ir = '0;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SHD;
            SHD: return m ? E1D : SHD;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SHD;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SHI;
            SHI: return m ? E1I : SHI;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SHI;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tap)
            CDR: sr_dr <= 4'hA;
            SHD: sr_dr <= {TDI, sr_dr[3:1]};
            UDR: upd_dr <= sr_dr;
            CIR: sr_ir <= 8'h01;
            SHI: sr_ir <= {TDI, sr_ir[7:1]};
            UIR: upd_ir <= sr_ir;
            default: ;
        endcase
        tap <= tap_next(tap, TMS);
    end

    always @(negedge TCK)
        TDO <= (tap == SHD) ? sr_dr[0] : (tap == SHI) ? sr_ir[0] : 1'b0;

    // pin monitor
    int          npulse = 0;
    logic [63:0] tms_v = '0;
    logic [63:0] tdi_v = '0;
    int          rv_cnt = 0;

    always @(posedge TCK) begin
        if (npulse < 64) begin
            tms_v[npulse] = TMS;
            tdi_v[npulse] = TDI;
        end
        npulse++;
    end

    always @(negedge CLK)
        if (rsp_valid) rv_cnt++;

    logic [31:0] upd_dr_m = '0;
    logic [31:0] upd_ir_m = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        npulse = 0;
        tms_v  = '0;
        tdi_v  = '0;
    endtask

    // reference: pulse train of a scan of L bits
    function automatic logic [63:0] exp_tms(bit ir, int L);
        logic [63:0] v = '0;
        int p = 0;
        if (L == 0) return v;
        v[p] = 1'b1;
        p++;
        if (ir) begin
            v[p] = 1'b1;
            p++;
        end
        p += 2;
        v[p + L - 1] = 1'b1;
        v[p + L] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] exp_tdi(bit ir, int L, logic [31:0] d);
        logic [63:0] v = '0;
        int pre = ir ? 4 : 3;
        for (int k = 0; k < L; k++) v[pre + k] = d[k];
        return v;
    endfunction

    // chain of width w: bit stream seen at TDO is capture value then TDI
    function automatic logic [31:0] exp_cap(int w, logic [31:0] c,
                                            logic [31:0] d, int L);
        logic [31:0] r = '0;
        for (int k = 0; k < L; k++) r[k] = (k < w) ? c[k] : d[k - w];
        return r;
    endfunction

    function automatic logic [31:0] exp_upd(int w, logic [31:0] c,
                                            logic [31:0] d, int L);
        logic [31:0] r = '0;
        for (int j = 0; j < w; j++) begin
            int i = j + L;
            r[j] = (i < w) ? c[i] : d[i - w];
        end
        return r;
    endfunction

    task automatic send(input bit ir, input int len, input logic [31:0] d,
                        input bit hold);
        int c = 0;
        @(negedge CLK);
        cmd_is_ir = ir;
        cmd_len   = LW'(len);
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && c < 500) begin
            @(negedge CLK);
            c++;
        end
        chk("accept_wait", cmd_ready, 1);
        clr_mon();
        @(posedge CLK);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // called just after the accept edge
    task automatic expect_rsp(input string tag, input bit ir, input int len,
                              input logic [31:0] d, input bit nxt_busy);
        int c = 0;
        int L = (len > MB) ? MB : len;
        int n = (L == 0) ? 0 : L + (ir ? 6 : 5);
        int w = ir ? 8 : 4;
        logic [31:0] cv = ir ? 32'h01 : 32'hA;
        logic [31:0] ed = exp_cap(w, cv, d, L);
        while (!rsp_valid && c < 2000) begin
            @(posedge CLK);
            #1;
            c++;
        end
        chk({tag, "/lat"}, c, 1 + 2 * DIV * n);
        chk({tag, "/data"}, rsp_data, ed);
        chk({tag, "/pulses"}, npulse, n);
        chk({tag, "/tms"}, tms_v, exp_tms(ir, L));
        chk({tag, "/tdi"}, tdi_v, exp_tdi(ir, L, d));
        chk({tag, "/ready"}, cmd_ready, 1);
        chk({tag, "/tck"}, TCK, 0);
        chk({tag, "/tap"}, tap == RTI, 1);
        if (L > 0) begin
            if (ir) upd_ir_m = exp_upd(w, cv, d, L);
            else    upd_dr_m = exp_upd(w, cv, d, L);
        end
        chk({tag, "/upd_dr"}, upd_dr, upd_dr_m);
        chk({tag, "/upd_ir"}, upd_ir, upd_ir_m);
        clr_mon();
        @(posedge CLK);
        #1;
        chk({tag, "/pulse1"}, rsp_valid, 0);
        chk({tag, "/busy"}, cmd_ready, !nxt_busy);
        chk({tag, "/held"}, rsp_data, ed);
    endtask

    // RST has just been released at a falling CLK edge
    task automatic init_check(input string tag, input int rv0);
        clr_mon();
        for (int e = 1; e <= 25; e++) begin
            @(posedge CLK);
            #1;
            if (e == 24) chk({tag, "/ready24"}, cmd_ready, 0);
            if (e == 25) chk({tag, "/ready25"}, cmd_ready, 1);
        end
        chk({tag, "/pulses"}, npulse, 6);
        chk({tag, "/tms"}, tms_v, 64'h1F);
        chk({tag, "/tdi"}, tdi_v, 0);
        chk({tag, "/tap"}, tap == RTI, 1);
        chk({tag, "/no_rsp"}, rv_cnt, rv0);
        chk({tag, "/tms_idle"}, TMS, 0);
    endtask

    initial begin
        int rv0;
        int c;
        bit ir;
        int ln;
        int ln2;
        logic [31:0] d;
        logic [31:0] d2;

        repeat (3) @(negedge CLK);
        chk("rst/tck", TCK, 0);
        chk("rst/tms", TMS, 1);
        chk("rst/tdi", TDI, 0);
        chk("rst/ready", cmd_ready, 0);
        chk("rst/rsp_valid", rsp_valid, 0);
        chk("rst/rsp_data", rsp_data, 0);
        RST = 1'b0;
        init_check("init", rv_cnt);

        send(0, 4, 32'hB, 0);
        expect_rsp("dr4", 0, 4, 32'hB, 0);
        chk("dr4/upd_plan", upd_dr, 4'b1011);
        chk("dr4/cap_plan", rsp_data, 32'hA);

        send(1, 8, 32'h3C, 0);
        expect_rsp("ir8", 1, 8, 32'h3C, 0);
        chk("ir8/upd_plan", upd_ir, 8'h3C);
        chk("ir8/cap_plan", rsp_data, 32'h01);

        d = $urandom;
        send(0, 0, d, 0);
        expect_rsp("len0", 0, 0, d, 0);

        d = $urandom;
        send(0, 40, d, 0);
        expect_rsp("len40", 0, 40, d, 0);

        for (int i = 0; i < 6; i++) begin
            ir = 1'($urandom_range(0, 1));
            ln = $urandom_range(1, MB);
            d  = $urandom;
            send(ir, ln, d, 0);
            expect_rsp($sformatf("rnd%0d", i), ir, ln, d, 0);
        end

        rv0 = rv_cnt;
        ln  = $urandom_range(1, 12);
        ln2 = $urandom_range(1, 12);
        d   = $urandom;
        d2  = $urandom;
        send(0, ln, d, 1);
        cmd_len  = LW'(ln2);
        cmd_data = d2;
        expect_rsp("b2bA", 0, ln, d, 1);
        cmd_valid = 1'b0;
        expect_rsp("b2bB", 0, ln2, d2, 0);
        chk("b2b/rsp_count", rv_cnt - rv0, 2);

        d = $urandom;
        send(0, 16, d, 0);
        c = 0;
        while (npulse < 6 && c < 500) begin
            @(negedge CLK);
            c++;
        end
        chk("midrst/reach", npulse, 6);
        rv0 = rv_cnt;
        #2 RST = 1'b1;
        #1;
        chk("midrst/tck", TCK, 0);
        chk("midrst/tms", TMS, 1);
        chk("midrst/ready", cmd_ready, 0);
        chk("midrst/rsp_valid", rsp_valid, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        init_check("reinit", rv0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
